// File: rtl/noc_pkg.sv
// Shared NoC router definitions: flit format, VC encoding, port indices and
// the round-robin pointer helper.
package noc_pkg;

   localparam int FLIT_W = 64;
   localparam int VC_BIT = 63;

   typedef logic [FLIT_W-1:0] flit_t;

   localparam int VC_EVEN = 0;
   localparam int VC_ODD  = 1;

   localparam int PORT_CW  = 0;
   localparam int PORT_CCW = 1;
   localparam int PORT_PE  = 2;
   localparam int PORT_NS  = 3;
   localparam int PORT_SN  = 4;

   // Pointer position just past the winner, wrapping N-1 -> 0.
   function automatic int rr_next(input int idx, input int n);
      return (idx >= n - 1) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/noc_out_port_arbiter_if.sv
// Output-port bundle: requester side (req/req_data/gnt) and link side
// (so/do_flit/ro), plus the exported polarity.
interface noc_out_port_arbiter_if #(
   parameter int N      = 4,
   parameter int FLIT_W = noc_pkg::FLIT_W
);

   logic [N-1:0]        req;
   logic [N*FLIT_W-1:0] req_data;
   logic [N-1:0]        gnt;
   logic                ro;
   logic                so;
   // "do" is a reserved word, so the outgoing flit is carried as do_flit.
   logic [FLIT_W-1:0]   do_flit;
   logic                polarity;

   modport master (
      input  req, req_data, ro,
      output gnt, so, do_flit, polarity
   );

   modport slave (
      output req, req_data, ro,
      input  gnt, so, do_flit, polarity
   );

endinterface

// File: rtl/noc_out_port_arbiter_rr.sv
// Combinational round-robin picker: first eligible index at or after ptr.
// gnt is only asserted while advance is high; winner is valid regardless.
module rr_arbiter #(
   parameter int N = 4
) (
   input  logic [N-1:0]         eligible,
   input  logic [$clog2(N)-1:0] ptr,
   input  logic                 advance,
   output logic [N-1:0]         gnt,
   output logic [$clog2(N)-1:0] winner
);

   localparam int PTR_W = $clog2(N);

   int   idx;
   logic found;

   always_comb begin
      gnt    = '0;
      winner = '0;
      found  = 1'b0;
      idx    = 0;
      for (int k = 0; k < N; k++) begin
         idx = int'(ptr) + k;
         if (idx >= N) idx = idx - N;
         if (!found && eligible[PTR_W'(idx)]) begin
            found  = 1'b1;
            winner = PTR_W'(idx);
         end
      end
      if (found && advance) gnt[winner] = 1'b1;
   end

endmodule

// File: rtl/noc_out_port_arbiter.sv
// Output-port controller: two single-flit VC buffers on an even/odd schedule;
// the current-polarity buffer is filled while the other one drives the link.
module noc_out_port_arbiter #(
   parameter int N      = 4,
   parameter int FLIT_W = noc_pkg::FLIT_W,
   parameter int VC_BIT = noc_pkg::VC_BIT
) (
   input logic                     clk,
   input logic                     reset,
   noc_out_port_arbiter_if.master  bus
);

   import noc_pkg::*;

   localparam int PTR_W = $clog2(N);

   logic                polarity;
   logic [1:0]          buf_valid;
   logic [FLIT_W-1:0]   buf_data [2];
   logic [PTR_W-1:0]    rr_ptr   [2];

   logic [FLIT_W-1:0]   flits    [N];
   logic [N-1:0]        flit_vc;
   logic [N-1:0]        vc_gnt   [2];
   logic [PTR_W-1:0]    vc_win   [2];
   logic [N-1:0]        gnt_cur;
   logic [PTR_W-1:0]    win_cur;
   logic                so_int;

   always_comb begin
      for (int i = 0; i < N; i++) begin
         flits[i]   = bus.req_data[i*FLIT_W +: FLIT_W];
         flit_vc[i] = flits[i][VC_BIT];
      end
   end

   for (genvar v = VC_EVEN; v <= VC_ODD; v++) begin : g_vc
      logic [N-1:0] elig;
      assign elig = bus.req & ((v == VC_ODD) ? flit_vc : ~flit_vc)
                  & {N{!buf_valid[v]}};

      rr_arbiter #(.N(N)) u_arb (
         .eligible (elig),
         .ptr      (rr_ptr[v]),
         .advance  (reset && (polarity == 1'(v))),
         .gnt      (vc_gnt[v]),
         .winner   (vc_win[v])
      );
   end

   assign gnt_cur = polarity ? vc_gnt[VC_ODD] : vc_gnt[VC_EVEN];
   assign win_cur = vc_win[polarity];

   // Link side reads the opposite-polarity buffer; it is never the one being written.
   assign so_int       = reset && buf_valid[~polarity];
   assign bus.so       = so_int;
   assign bus.do_flit  = so_int ? buf_data[~polarity] : '0;
   assign bus.gnt      = gnt_cur;
   assign bus.polarity = polarity;

   always_ff @(posedge clk) begin
      if (!reset) begin
         polarity    <= 1'b0;
         buf_valid   <= '0;
         buf_data[0] <= '0;
         buf_data[1] <= '0;
         rr_ptr[0]   <= '0;
         rr_ptr[1]   <= '0;
      end else begin
         polarity <= ~polarity;
         if (so_int && bus.ro) buf_valid[~polarity] <= 1'b0;
         if (|gnt_cur) begin
            buf_valid[polarity] <= 1'b1;
            buf_data[polarity]  <= flits[win_cur];
            rr_ptr[polarity]    <= PTR_W'(rr_next(int'(win_cur), N));
         end
      end
   end

endmodule

// File: tb/tb_noc_out_port_arbiter.sv
// Scenario bench for noc_out_port_arbiter: grants checked inline per task,
// emitted flits checked against per-VC scoreboard queues by a link monitor.
module tb_noc_out_port_arbiter;
   import noc_pkg::*;

   logic  clk = 1'b0;
   logic  reset = 1'b0;
   flit_t flit [4];
   flit_t sb0 [$];
   flit_t sb1 [$];
   logic  ep = 1'b0;
   int    n_checks = 0;
   int    n_fail = 0;

   noc_out_port_arbiter_if #(.N(4), .FLIT_W(64)) bus ();

   noc_out_port_arbiter #(.N(4), .FLIT_W(64), .VC_BIT(63)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   always_comb begin
      for (int i = 0; i < 4; i++) bus.req_data[i*64 +: 64] = flit[i];
   end

   // Link monitor: every emitted flit must be the oldest expected one of its VC.
   always begin
      @(negedge clk);
      #2;
      n_checks++;
      if (bus.so !== 1'b1) begin
         if (bus.so !== 1'b0 || bus.do_flit !== 64'h0) begin
            n_fail++;
            $display("FAIL idle_link: so=%b do=%h, required so=0 do=0", bus.so, bus.do_flit);
         end
      end else if (bus.polarity === 1'b1) begin
         if (sb0.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_vc0_flit: do=%h, required no flit", bus.do_flit);
         end else begin
            if (bus.do_flit !== sb0[0]) begin
               n_fail++;
               $display("FAIL vc0_data: do=%h, required %h", bus.do_flit, sb0[0]);
            end
            if (bus.ro) void'(sb0.pop_front());
         end
      end else begin
         if (sb1.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_vc1_flit: do=%h, required no flit", bus.do_flit);
         end else begin
            if (bus.do_flit !== sb1[0]) begin
               n_fail++;
               $display("FAIL vc1_data: do=%h, required %h", bus.do_flit, sb1[0]);
            end
            if (bus.ro) void'(sb1.pop_front());
         end
      end
   end

   task automatic next_cycle();
      @(posedge clk);
      ep = reset ? ~ep : 1'b0;
      @(negedge clk);
   endtask

   task automatic wait_pol(input logic p);
      if (ep != p) next_cycle();
   endtask

   task automatic push_exp(input logic vc, input flit_t f);
      if (vc) sb1.push_back(f);
      else    sb0.push_back(f);
   endtask

   task automatic test_reset();
      bus.req = 4'b1111;
      bus.ro  = 1'b1;
      for (int i = 0; i < 4; i++) flit[i] = 64'h0000_0000_0000_0100 + 64'(i);
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         #1;
         n_checks++;
         if (bus.so !== 1'b0 || bus.do_flit !== 64'h0 || bus.gnt !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_outputs: so=%b do=%h gnt=%b, required 0/0/0000",
                     bus.so, bus.do_flit, bus.gnt);
         end
      end
      reset   = 1'b1;
      bus.req = 4'b0000;
      for (int c = 0; c < 4; c++) begin
         #1;
         n_checks++;
         if (bus.polarity !== 1'(c % 2)) begin
            n_fail++;
            $display("FAIL polarity_toggle: cycle %0d polarity=%b, required %0d",
                     c, bus.polarity, c % 2);
         end
         next_cycle();
      end
   endtask

   task automatic test_single_flit();
      wait_pol(1'b0);
      bus.req = 4'b0010;
      flit[1] = 64'h0002000000006840;
      #1;
      n_checks++;
      if (bus.gnt !== 4'b0010) begin
         n_fail++;
         $display("FAIL single_gnt: gnt=%b, required 0010", bus.gnt);
      end
      push_exp(1'b0, 64'h0002000000006840);
      next_cycle();
      bus.req = 4'b0000;
      #1;
      n_checks++;
      if (bus.so !== 1'b1 || bus.do_flit !== 64'h0002000000006840) begin
         n_fail++;
         $display("FAIL single_out: so=%b do=%h, required 1 0002000000006840",
                  bus.so, bus.do_flit);
      end
      next_cycle();
      #1;
      n_checks++;
      if (bus.so !== 1'b0) begin
         n_fail++;
         $display("FAIL single_consumed: so=%b, required 0", bus.so);
      end
   endtask

   task automatic test_round_robin();
      int exp_idx [4];
      exp_idx = '{0, 1, 3, 0};
      wait_pol(1'b1);
      for (int i = 0; i < 4; i++) flit[i] = 64'h8012000000000000 | 64'(i);
      bus.req = 4'b1011;
      bus.ro  = 1'b1;
      for (int k = 0; k < 4; k++) begin
         #1;
         n_checks++;
         if (bus.gnt !== 4'(1 << exp_idx[k])) begin
            n_fail++;
            $display("FAIL rr_gnt_%0d: gnt=%b, required %b", k, bus.gnt, 4'(1 << exp_idx[k]));
         end
         push_exp(1'b1, flit[exp_idx[k]]);
         next_cycle();
         #1;
         n_checks++;
         if (bus.gnt !== 4'b0000) begin
            n_fail++;
            $display("FAIL rr_even_idle_%0d: gnt=%b, required 0000", k, bus.gnt);
         end
         next_cycle();
      end
      bus.req = 4'b0000;
      next_cycle();
      next_cycle();
   endtask

   task automatic test_vc_mismatch();
      wait_pol(1'b0);
      bus.req = 4'b0100;
      flit[2] = 64'h8010000000000000;
      #1;
      n_checks++;
      if (bus.gnt !== 4'b0000) begin
         n_fail++;
         $display("FAIL vc_wrong_phase: gnt=%b, required 0000", bus.gnt);
      end
      next_cycle();
      #1;
      n_checks++;
      if (bus.gnt !== 4'b0100) begin
         n_fail++;
         $display("FAIL vc_right_phase: gnt=%b, required 0100", bus.gnt);
      end
      push_exp(1'b1, 64'h8010000000000000);
      next_cycle();
      bus.req = 4'b0000;
      next_cycle();
   endtask

   task automatic test_back_to_back();
      wait_pol(1'b0);
      flit[2] = 64'h0000000000000a02;
      flit[3] = 64'h8000000000000b03;
      bus.req = 4'b1100;
      bus.ro  = 1'b1;
      for (int k = 0; k < 6; k++) begin
         #1;
         n_checks++;
         if (bus.gnt !== (ep ? 4'b1000 : 4'b0100)) begin
            n_fail++;
            $display("FAIL b2b_gnt_%0d: gnt=%b, required %b", k, bus.gnt,
                     ep ? 4'b1000 : 4'b0100);
         end
         push_exp(ep, ep ? flit[3] : flit[2]);
         if (k > 0) begin
            n_checks++;
            if (bus.so !== 1'b1) begin
               n_fail++;
               $display("FAIL b2b_so_%0d: so=%b, required 1", k, bus.so);
            end
         end
         next_cycle();
      end
      bus.req = 4'b0000;
      next_cycle();
      next_cycle();
   endtask

   task automatic test_backpressure();
      wait_pol(1'b0);
      bus.ro  = 1'b0;
      bus.req = 4'b0001;
      flit[0] = 64'h00100000ffffffff;
      #1;
      n_checks++;
      if (bus.gnt !== 4'b0001) begin
         n_fail++;
         $display("FAIL bp_first_gnt: gnt=%b, required 0001", bus.gnt);
      end
      push_exp(1'b0, 64'h00100000ffffffff);
      next_cycle();
      bus.req = 4'b1000;
      flit[3] = 64'h0000000000000333;
      for (int r = 0; r < 2; r++) begin
         #1;
         n_checks++;
         if (bus.so !== 1'b1 || bus.do_flit !== 64'h00100000ffffffff || bus.gnt !== 4'b0000) begin
            n_fail++;
            $display("FAIL bp_hold_%0d: so=%b do=%h gnt=%b, required 1 00100000ffffffff 0000",
                     r, bus.so, bus.do_flit, bus.gnt);
         end
         next_cycle();
         #1;
         n_checks++;
         if (bus.so !== 1'b0 || bus.gnt !== 4'b0000) begin
            n_fail++;
            $display("FAIL bp_blocked_%0d: so=%b gnt=%b, required 0 0000", r, bus.so, bus.gnt);
         end
         next_cycle();
      end
      bus.ro = 1'b1;
      #1;
      n_checks++;
      if (bus.so !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_release: so=%b, required 1", bus.so);
      end
      next_cycle();
      #1;
      n_checks++;
      if (bus.gnt !== 4'b1000) begin
         n_fail++;
         $display("FAIL bp_next_gnt: gnt=%b, required 1000", bus.gnt);
      end
      push_exp(1'b0, 64'h0000000000000333);
      next_cycle();
      bus.req = 4'b0000;
      next_cycle();
      #1;
      n_checks++;
      if (sb0.size() + sb1.size() != 0) begin
         n_fail++;
         $display("FAIL bp_drained: %0d flits outstanding, required 0", sb0.size() + sb1.size());
      end
   endtask

   task automatic test_reset_midop();
      wait_pol(1'b0);
      bus.ro  = 1'b0;
      bus.req = 4'b0001;
      flit[0] = 64'h0000000000000aaa;
      flit[1] = 64'h8000000000000bbb;
      #1;
      n_checks++;
      if (bus.gnt !== 4'b0001) begin
         n_fail++;
         $display("FAIL mid_gnt_vc0: gnt=%b, required 0001", bus.gnt);
      end
      push_exp(1'b0, flit[0]);
      next_cycle();
      bus.req = 4'b0010;
      #1;
      n_checks++;
      if (bus.gnt !== 4'b0010) begin
         n_fail++;
         $display("FAIL mid_gnt_vc1: gnt=%b, required 0010", bus.gnt);
      end
      push_exp(1'b1, flit[1]);
      next_cycle();
      bus.req = 4'b0011;
      for (int c = 0; c < 2; c++) begin
         #1;
         n_checks++;
         if (bus.gnt !== 4'b0000 || bus.so !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_full_%0d: gnt=%b so=%b, required 0000 1", c, bus.gnt, bus.so);
         end
         next_cycle();
      end
      reset = 1'b0;
      sb0.delete();
      sb1.delete();
      for (int c = 0; c < 2; c++) begin
         #1;
         n_checks++;
         if (bus.so !== 1'b0 || bus.do_flit !== 64'h0 || bus.gnt !== 4'b0000) begin
            n_fail++;
            $display("FAIL mid_reset_%0d: so=%b do=%h gnt=%b, required 0 0 0000",
                     c, bus.so, bus.do_flit, bus.gnt);
         end
         next_cycle();
      end
      reset   = 1'b1;
      bus.req = 4'b0000;
      bus.ro  = 1'b1;
      for (int c = 0; c < 6; c++) begin
         #1;
         n_checks++;
         if (bus.so !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_stale_%0d: so=%b do=%h, required so=0", c, bus.so, bus.do_flit);
         end
         next_cycle();
      end
   endtask

   initial begin
      bus.req = 4'b0000;
      bus.ro  = 1'b1;
      for (int i = 0; i < 4; i++) flit[i] = '0;
      test_reset();
      test_single_flit();
      test_round_robin();
      test_vc_mismatch();
      test_back_to_back();
      test_backpressure();
      test_reset_midop();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/noc_out_port_arbiter.md
Name: noc_out_port_arbiter

Overview:
- Output-port controller for the mesh NoC router. It shares one outgoing link (cw, ccw, pe, ns or sn) among N input virtual-channel buffers.
- It arbitrates round-robin, holds one single-flit output buffer per virtual channel, and runs the even/odd polarity schedule.
- In each cycle, the buffer of the current-polarity VC is loaded internally while the buffer of the opposite-polarity VC drives the external link.
- One instance is placed per output port inside the router.

Parameters:
- N, 4, number of requesting input buffers (N >= 2).
- FLIT_W, 64, flit width in bits.
- VC_BIT, 63, flit bit that selects the virtual channel (0 = even, 1 = odd).

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-low reset.
- req  input  N  req[i] = input buffer i holds a flit routed to this port.
- req_data  input  N*FLIT_W  flit of requester i, at bits [i*FLIT_W +: FLIT_W].
- gnt  output  N  one-hot combinational pop; requester i dequeues at the next posedge.
- ro  input  1  downstream ready.
- so  output  1  outgoing flit valid.
- do  output  FLIT_W  outgoing flit.
- polarity  output  1  current polarity; exported to the router as polarity_out.

Behaviour:
- Reset: clk is the clock; reset is synchronous and active-low. At a posedge with reset==0:
  - polarity<=0, buf_valid[0..1]<=0, buf_data<=0, rr_ptr[0..1]<=0.
  - Outputs while in reset: so=0, do=0, gnt=0.
  - Flits held mid-operation are discarded. Requesters see no gnt, so they keep their flits.
- Polarity: toggles on every posedge after reset is released.
- External side:
  - so = buf_valid[~polarity].
  - do = buf_data[~polarity] when so=1, otherwise all-zero.
  - At a posedge with so&&ro, buf_valid[~polarity]<=0.
  - With so&&!ro, the flit is held and presented again two cycles later, when the polarity next matches.
- Internal side:
  - eligible[i] = req[i] && (req_data[i][VC_BIT]==polarity) && !buf_valid[polarity].
  - Winner = first eligible index scanning rr_ptr[polarity], rr_ptr[polarity]+1, … mod N.
  - gnt = onehot(winner), or 0 if nothing is eligible.
  - At the posedge: buf_data[polarity]<=winning flit, buf_valid[polarity]<=1, rr_ptr[polarity]<=(winner+1) mod N.
  - rr_ptr is left unchanged when nothing is granted.
- Collision freedom: one VC buffer is written while the other is drained, so a read and a write never target the same buffer in the same cycle.
- Flits are not modified here; hop-field updates belong to the input stage.
- Latency: a flit granted in cycle t appears on so/do in cycle t+1. This is the minimum latency.
- Throughput: at most one flit per cycle on the link, alternating VCs.
- Boundaries:
  - Wrong-VC requesters wait without being granted.
  - If the target VC buffer is full, gnt=0 for that VC.
  - Pointer wrap is N-1 → 0.
  - All N requesting the same VC are served in strict rotation, with no starvation.
  - If ro is tied 0, both buffers fill and gnt stays 0.

Decomposition:
- Package noc_pkg:
  - FLIT_W=64, VC_BIT=63.
  - flit_t typedef for logic [63:0].
  - VC_EVEN=0, VC_ODD=1.
  - Port index constants PORT_CW, PORT_CCW, PORT_PE, PORT_NS, PORT_SN.
- Sub-module rr_arbiter (parameter N):
  - Inputs: eligible vector, pointer, advance strobe.
  - Outputs: one-hot gnt and winner index.
  - Instantiated once per VC; the top level muxes gnt by polarity.
- Buffers, polarity flop and handshake logic live in the top module.

Test Plan:
- Reset checks:
  - Hold reset=0 for 2 cycles with req=4'b1111 → so=0, do=0, gnt=0.
  - After release, polarity=0 and toggles every cycle.
- Single flit:
  - At polarity=0, req[1]=1 with 64'h0002000000006840 (VC 0) → gnt=4'b0010 that cycle.
  - Next cycle (polarity=1): so=1, do=64'h0002000000006840. With ro=1 the flit is consumed, so=0 after.
- Round-robin:
  - req=4'b1011, all with VC-1 flits (64'h8012000000000000 | i), ro=1.
  - Successive odd-phase grants are 0001, 0010, 1000, 0001.
- VC mismatch:
  - req[2]=1 with a VC-1 flit (64'h8010000000000000) during polarity=0 → gnt=0.
  - Next cycle → gnt=4'b0100.
- Backpressure:
  - ro=0 with VC-0 flit 64'h00100000ffffffff buffered → so=1 every other cycle, do is stable, and further VC-0 requests get gnt=0.
  - Set ro=1 → flit drains, and the next VC-0 request is granted in the following even phase.
- Reset mid-operation:
  - Both buffers valid, assert reset=0 → so=0 next cycle.
  - After release, the old flits are never emitted.
